// File: rtl/triple_sequencer_if.sv
// Result stream of triple_sequencer: one Pythagorean triple plus the (m,n) pair
// that produced it, moved with a valid/ready handshake.
interface triple_sequencer_if #(
   parameter int unsigned N_W = 15
);
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_a;
   logic [31:0]    out_b;
   logic [31:0]    out_c;
   logic [N_W-1:0] out_m;
   logic [N_W-1:0] out_n;

   modport master (
      output out_valid, out_a, out_b, out_c, out_m, out_n,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_a, out_b, out_c, out_m, out_n,
      output out_ready
   );
endinterface

// File: rtl/triple_sequencer.sv
// Sweeps all pairs max_m >= m > n >= 1 and streams (m^2-n^2, 2mn, m^2+n^2).
// Optional PRIMITIVE_FILTER_EN adds a CHECK state that passes only primitive triples.
module triple_sequencer #(
   parameter int unsigned N_W   = 15,
   parameter int unsigned CNT_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_W-1:0]            max_m,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_W-1:0]          count,
   triple_sequencer_if.master        out_if
);

`ifdef PRIMITIVE_FILTER_EN
   typedef enum logic [2:0] {
      IDLE, CHECK, ISSUE, HOLD, ADVANCE, DONE
   } state_e;
   localparam state_e PAIR_ST = CHECK;
`else
   typedef enum logic [2:0] {
      IDLE, ISSUE, HOLD, ADVANCE, DONE
   } state_e;
   localparam state_e PAIR_ST = ISSUE;
`endif

   state_e state_q, state_d;

   logic [N_W-1:0]   m_q, m_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [N_W-1:0]   mmax_q, mmax_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      c_q, c_d;
   logic [N_W-1:0]   om_q, om_d;
   logic [N_W-1:0]   on_q, on_d;

`ifdef PRIMITIVE_FILTER_EN
   logic [N_W-1:0]   x_q, x_d;
   logic [N_W-1:0]   y_q, y_d;
   logic             diff_even;
   assign diff_even = ~(m_q[0] ^ n_q[0]);
`endif

   // One extra bit so that m+1 never wraps when mmax is all ones.
   logic [N_W:0]     m_inc;
   logic [N_W:0]     n_inc;
   logic             n_step;
   logic             m_step;
   assign m_inc  = {1'b0, m_q} + 1'b1;
   assign n_inc  = {1'b0, n_q} + 1'b1;
   assign n_step = n_inc < {1'b0, m_q};
   assign m_step = m_inc <= {1'b0, mmax_q};

   logic [31:0] m32, n32, m_sq, n_sq, gen_a, gen_b, gen_c;
   assign m32   = 32'(m_q);
   assign n32   = 32'(n_q);
   assign m_sq  = m32 * m32;
   assign n_sq  = n32 * n32;
   assign gen_a = m_sq - n_sq;
   assign gen_b = (m32 * n32) << 1;
   assign gen_c = m_sq + n_sq;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (max_m >= N_W'(2)) ? PAIR_ST : DONE;
`ifdef PRIMITIVE_FILTER_EN
         CHECK: begin
            if (diff_even)       state_d = ADVANCE;
            else if (x_q == y_q) state_d = (x_q == N_W'(1)) ? ISSUE : ADVANCE;
         end
`endif
         ISSUE:   state_d = HOLD;
         HOLD:    if (out_if.out_ready) state_d = ADVANCE;
         ADVANCE: state_d = (n_step || m_step) ? PAIR_ST : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy             = state_q != IDLE;
      done             = state_q == DONE;
      out_if.out_valid = state_q == HOLD;
      out_if.out_a     = a_q;
      out_if.out_b     = b_q;
      out_if.out_c     = c_q;
      out_if.out_m     = om_q;
      out_if.out_n     = on_q;
      count            = count_q;
   end

   always_comb begin
      m_d     = m_q;
      n_d     = n_q;
      mmax_d  = mmax_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      om_d    = om_q;
      on_d    = on_q;
`ifdef PRIMITIVE_FILTER_EN
      x_d     = x_q;
      y_d     = y_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               count_d = '0;
               if (max_m >= N_W'(2)) begin
                  m_d    = N_W'(2);
                  n_d    = N_W'(1);
                  mmax_d = max_m;
`ifdef PRIMITIVE_FILTER_EN
                  x_d    = N_W'(2);
                  y_d    = N_W'(1);
`endif
               end
            end
         end
`ifdef PRIMITIVE_FILTER_EN
         // Subtractive gcd: one subtraction per cycle until x == y.
         CHECK: begin
            if (!diff_even && (x_q != y_q)) begin
               if (x_q > y_q) x_d = x_q - y_q;
               else           y_d = y_q - x_q;
            end
         end
`endif
         ISSUE: begin
            a_d  = gen_a;
            b_d  = gen_b;
            c_d  = gen_c;
            om_d = m_q;
            on_d = n_q;
         end
         HOLD: begin
            if (out_if.out_ready) count_d = count_q + 1'b1;
         end
         ADVANCE: begin
            if (n_step) begin
               n_d = N_W'(n_inc);
`ifdef PRIMITIVE_FILTER_EN
               x_d = m_q;
               y_d = N_W'(n_inc);
`endif
            end else if (m_step) begin
               m_d = N_W'(m_inc);
               n_d = N_W'(1);
`ifdef PRIMITIVE_FILTER_EN
               x_d = N_W'(m_inc);
               y_d = N_W'(1);
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q     <= '0;
         n_q     <= '0;
         mmax_q  <= '0;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         om_q    <= '0;
         on_q    <= '0;
`ifdef PRIMITIVE_FILTER_EN
         x_q     <= '0;
         y_q     <= '0;
`endif
      end else begin
         m_q     <= m_d;
         n_q     <= n_d;
         mmax_q  <= mmax_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         om_q    <= om_d;
         on_q    <= on_d;
`ifdef PRIMITIVE_FILTER_EN
         x_q     <= x_d;
         y_q     <= y_d;
`endif
      end
   end

endmodule

// File: tb/tb_triple_sequencer.sv
// Directed bench for triple_sequencer: table of sweeps against a hand-written triple list,
// plus backpressure and mid-sweep reset sequences. Honours PRIMITIVE_FILTER_EN.
module tb_triple_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [14:0] max_m = '0;
   logic        busy, done;
   logic [31:0] count;

   int n_chk  = 0;
   int n_pass = 0;

   triple_sequencer_if #(.N_W(15)) bus ();

   triple_sequencer #(.N_W(15), .CNT_W(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .max_m  (max_m),
      .busy   (busy),
      .done   (done),
      .count  (count),
      .out_if (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m, n, a, b, c;
   } trip_t;

   typedef struct {
      logic [14:0] max_m;
      bit          rdy_toggle;
      bit          poke;
      int          exp_cnt;
      int          exp_lat;
   } sweep_t;

`ifdef PRIMITIVE_FILTER_EN
   localparam int N_TRIP = 4;
   localparam int LAT    = 4;
`else
   localparam int N_TRIP = 6;
   localparam int LAT    = 2;
`endif

   trip_t  tbl [N_TRIP];
   sweep_t sweeps [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      else             n_pass++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_sweep(input sweep_t v);
      int k     = 0;
      int cyc   = 0;
      int first = -1;
      bit seen_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      max_m = v.max_m;
      bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (cyc < 400) begin
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         if (v.poke && cyc == 4) begin
            start = 1'b1;
            max_m = 15'd9;
         end else begin
            start = 1'b0;
         end
         bus.out_ready = v.rdy_toggle ? ((cyc % 2) == 1) : 1'b1;
         if (bus.out_valid) begin
            if (first < 0) first = cyc;
            if (bus.out_ready) begin
               if (k < N_TRIP) begin
                  chk("out_m", 32'(bus.out_m), tbl[k].m);
                  chk("out_n", 32'(bus.out_n), tbl[k].n);
                  chk("out_a", bus.out_a, tbl[k].a);
                  chk("out_b", bus.out_b, tbl[k].b);
                  chk("out_c", bus.out_c, tbl[k].c);
               end
               k++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", 32'(seen_done), 32'd1);
      chk("count", count, v.exp_cnt);
      chk("accepts", k, v.exp_cnt);
      if (v.exp_cnt > 0) chk("first_valid_latency", first, v.exp_lat);
      else               chk("no_valid_seen", first, -1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ha, hb, hc;
      bit          stable;
      int          w;
      bit          got;

`ifdef PRIMITIVE_FILTER_EN
      tbl[0] = '{2, 1, 3, 4, 5};
      tbl[1] = '{3, 2, 5, 12, 13};
      tbl[2] = '{4, 1, 15, 8, 17};
      tbl[3] = '{4, 3, 7, 24, 25};
      sweeps[0] = '{15'd3, 1'b0, 1'b0, 2, LAT};
      sweeps[1] = '{15'd0, 1'b0, 1'b0, 0, LAT};
      sweeps[2] = '{15'd1, 1'b0, 1'b0, 0, LAT};
      sweeps[3] = '{15'd2, 1'b1, 1'b0, 1, LAT};
      sweeps[4] = '{15'd4, 1'b1, 1'b0, 4, LAT};
      sweeps[5] = '{15'd4, 1'b0, 1'b1, 4, LAT};
`else
      tbl[0] = '{2, 1, 3, 4, 5};
      tbl[1] = '{3, 1, 8, 6, 10};
      tbl[2] = '{3, 2, 5, 12, 13};
      tbl[3] = '{4, 1, 15, 8, 17};
      tbl[4] = '{4, 2, 12, 16, 20};
      tbl[5] = '{4, 3, 7, 24, 25};
      sweeps[0] = '{15'd3, 1'b0, 1'b0, 3, LAT};
      sweeps[1] = '{15'd0, 1'b0, 1'b0, 0, LAT};
      sweeps[2] = '{15'd1, 1'b0, 1'b0, 0, LAT};
      sweeps[3] = '{15'd2, 1'b1, 1'b0, 1, LAT};
      sweeps[4] = '{15'd4, 1'b1, 1'b0, 6, LAT};
      sweeps[5] = '{15'd4, 1'b0, 1'b1, 6, LAT};
`endif

      bus.out_ready = 1'b1;
      do_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_a", bus.out_a, 32'd0);
      chk("rst_c", bus.out_c, 32'd0);
      chk("rst_m", 32'(bus.out_m), 32'd0);
      chk("rst_count", count, 32'd0);

      for (int i = 0; i < 6; i++) run_sweep(sweeps[i]);

      // Backpressure: hold the first triple for 10 cycles.
      @(negedge clk);
      bus.out_ready = 1'b0;
      start = 1'b1;
      max_m = 15'd2;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (w = 0; w < 20; w++) begin
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("bp_valid_seen", 32'(got), 32'd1);
      ha = bus.out_a;
      hb = bus.out_b;
      hc = bus.out_c;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_a != ha || bus.out_b != hb || bus.out_c != hc)
            stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      chk("bp_a", bus.out_a, 32'd3);
      chk("bp_b", bus.out_b, 32'd4);
      chk("bp_c", bus.out_c, 32'd5);
      chk("bp_count_held", count, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("bp_single_accept", count, 32'd1);
      got = 1'b0;
      for (w = 0; w < 20; w++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("bp_done", 32'(got), 32'd1);
      chk("bp_count", count, 32'd1);
      @(negedge clk);

      // Reset while holding the second triple.
      @(negedge clk);
      bus.out_ready = 1'b1;
      start = 1'b1;
      max_m = 15'd3;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      w = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (bus.out_valid) begin
            w++;
            if (w == 2) begin
               bus.out_ready = 1'b0;
               got = 1'b1;
               break;
            end
         end
         @(negedge clk);
      end
      chk("rst_hold_reached", 32'(got), 32'd1);
      @(negedge clk);
      chk("rst_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("rst_hold_count", count, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", count, 32'd0);
      chk("abort_a", bus.out_a, 32'd0);
      chk("abort_b", bus.out_b, 32'd0);
      chk("abort_n", 32'(bus.out_n), 32'd0);
      run_sweep(sweeps[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
